// File: rtl/elevator_pkg.sv
// Shared types for the elevator sequencer: display state codes and floor indexing.
package elevator_pkg;

  localparam int DEFAULT_NUM_FLOORS = 8;

  // Codes are consumed directly by the VGA controller.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10,
    DOOR = 2'b11
  } sim_state_t;

  typedef logic [$clog2(DEFAULT_NUM_FLOORS)-1:0] floor_idx_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer plus rising-edge pulse for a vector of raw button levels.
// A rising input produces a one-clk pulse two edges later.
module btn_sync_edge #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] pulse
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign pulse = sync2 & ~prev;

endmodule

// File: rtl/elevator_sequencer.sv
// Elevator car sequencer: collects floor calls and drives the car through IDLE/UP/DOWN/DOOR.
// Optional door_hold input is enabled by defining ELEV_DOOR_HOLD_EN.
module elevator_sequencer
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEFAULT_NUM_FLOORS,
  parameter int MOVE_TICKS = 16,
  parameter int DOOR_TICKS = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
`ifdef ELEV_DOOR_HOLD_EN
  input  logic                          door_hold,
`endif
  input  logic [NUM_FLOORS-1:0]         req_btn,
  output logic [NUM_FLOORS-1:0]         destination,
  output logic [1:0]                    sim_state,
  output logic [$clog2(NUM_FLOORS)-1:0] current_floor,
  output logic                          door_open
);

  localparam int FLOOR_W = $clog2(NUM_FLOORS);
  localparam int MOVE_W  = $clog2(MOVE_TICKS + 1);
  localparam int DOOR_W  = $clog2(DOOR_TICKS + 1);

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_UP   = 2'(UP);
  localparam logic [1:0] S_DOWN = 2'(DOWN);
  localparam logic [1:0] S_DOOR = 2'(DOOR);

  localparam logic [MOVE_W-1:0] MOVE_LAST = MOVE_W'(MOVE_TICKS - 1);
  localparam logic [DOOR_W-1:0] DOOR_LAST = DOOR_W'(DOOR_TICKS - 1);

  logic [1:0]            state, state_n;
  logic [FLOOR_W-1:0]    floor_q, floor_n, next_floor;
  logic [MOVE_W-1:0]     move_cnt, move_n;
  logic [DOOR_W-1:0]     door_cnt, door_n;
  logic                  dir_up, dir_n;
  logic [NUM_FLOORS-1:0] dest, dest_n;
  logic [NUM_FLOORS-1:0] press, set_mask, clr_mask, pend;
  logic                  door_restart, door_freeze;

  function automatic logic any_above(input logic [NUM_FLOORS-1:0] m, input logic [FLOOR_W-1:0] f);
    any_above = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++)
      if (m[i] && (i > int'(f))) any_above = 1'b1;
  endfunction

  function automatic logic any_below(input logic [NUM_FLOORS-1:0] m, input logic [FLOOR_W-1:0] f);
    any_below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++)
      if (m[i] && (i < int'(f))) any_below = 1'b1;
  endfunction

  btn_sync_edge #(.WIDTH(NUM_FLOORS)) u_btn_sync_edge (
    .clk   (clk),
    .rst   (rst),
    .din   (req_btn),
    .pulse (press)
  );

  // A call for the floor whose door is open only re-opens the door.
  always_comb begin
    set_mask = press;
    if (state == S_DOOR) set_mask[floor_q] = 1'b0;
  end

  assign pend         = dest | set_mask;
  assign door_restart = (state == S_DOOR) && press[floor_q];
`ifdef ELEV_DOOR_HOLD_EN
  assign door_freeze  = door_restart || door_hold;
`else
  assign door_freeze  = door_restart;
`endif
  assign next_floor   = (state == S_DOWN) ? floor_q - FLOOR_W'(1) : floor_q + FLOOR_W'(1);

  always_comb begin
    state_n  = state;
    floor_n  = floor_q;
    move_n   = move_cnt;
    door_n   = door_cnt;
    dir_n    = dir_up;
    clr_mask = '0;
    case (state)
      S_IDLE: begin
        if (dest[floor_q]) begin
          state_n           = S_DOOR;
          door_n            = '0;
          clr_mask[floor_q] = 1'b1;
        end else if (any_above(dest, floor_q)) begin
          state_n = S_UP;
          move_n  = '0;
          dir_n   = 1'b1;
        end else if (any_below(dest, floor_q)) begin
          state_n = S_DOWN;
          move_n  = '0;
          dir_n   = 1'b0;
        end
      end
      S_UP, S_DOWN: begin
        if (tick) begin
          if (move_cnt == MOVE_LAST) begin
            move_n  = '0;
            floor_n = next_floor;
            if (pend[next_floor]) begin
              state_n              = S_DOOR;
              door_n               = '0;
              clr_mask[next_floor] = 1'b1;
            end else if ((state == S_UP) && any_above(pend, next_floor)) begin
              state_n = S_UP;
            end else if ((state == S_DOWN) && any_below(pend, next_floor)) begin
              state_n = S_DOWN;
            end else if (any_above(pend, next_floor)) begin
              state_n = S_UP;
              dir_n   = 1'b1;
            end else if (any_below(pend, next_floor)) begin
              state_n = S_DOWN;
              dir_n   = 1'b0;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            move_n = move_cnt + MOVE_W'(1);
          end
        end
      end
      default: begin
        if (door_freeze) begin
          door_n = '0;
        end else if (tick) begin
          if (door_cnt == DOOR_LAST) begin
            door_n = '0;
            move_n = '0;
            // Keep sweeping in the last travel direction before reversing.
            if (dir_up && any_above(pend, floor_q)) begin
              state_n = S_UP;
            end else if (!dir_up && any_below(pend, floor_q)) begin
              state_n = S_DOWN;
            end else if (any_above(pend, floor_q)) begin
              state_n = S_UP;
              dir_n   = 1'b1;
            end else if (any_below(pend, floor_q)) begin
              state_n = S_DOWN;
              dir_n   = 1'b0;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            door_n = door_cnt + DOOR_W'(1);
          end
        end
      end
    endcase
  end

  // Clear wins over a same-edge set so an arrival-edge press is still serviced.
  assign dest_n = (dest | set_mask) & ~clr_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      floor_q  <= '0;
      move_cnt <= '0;
      door_cnt <= '0;
      dir_up   <= 1'b1;
      dest     <= '0;
    end else begin
      state    <= state_n;
      floor_q  <= floor_n;
      move_cnt <= move_n;
      door_cnt <= door_n;
      dir_up   <= dir_n;
      dest     <= dest_n;
    end
  end

  assign destination   = dest;
  assign sim_state     = state;
  assign current_floor = floor_q;
  assign door_open     = (state == S_DOOR);

endmodule

// File: tb/tb_elevator_sequencer.sv
// Directed bench for elevator_sequencer with MOVE_TICKS=4, DOOR_TICKS=3.
module tb_elevator_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b1;
  logic [7:0] req_btn = 8'h00;
  logic [7:0] destination;
  logic [1:0] sim_state;
  logic [2:0] current_floor;
  logic       door_open;
`ifdef ELEV_DOOR_HOLD_EN
  logic       door_hold = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       tick;
    logic [7:0] btn;
    logic [7:0] dest;
    logic [1:0] st;
    logic [2:0] flr;
    logic       door;
  } vec_t;

  vec_t vt[36];

  logic [1:0] seq_st[$];
  logic [2:0] seq_fl[$];
  logic [1:0] prev_st;
  int         stops;

  always #5 clk = ~clk;

  elevator_sequencer #(
    .NUM_FLOORS (8),
    .MOVE_TICKS (4),
    .DOOR_TICKS (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
`ifdef ELEV_DOOR_HOLD_EN
    .door_hold     (door_hold),
`endif
    .req_btn       (req_btn),
    .destination   (destination),
    .sim_state     (sim_state),
    .current_floor (current_floor),
    .door_open     (door_open)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    req_btn = 8'h00;
    tick    = 1'b1;
`ifdef ELEV_DOOR_HOLD_EN
    door_hold = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Counts door openings at a given floor over n cycles.
  task automatic run_count(input int n, input logic [2:0] flr);
    for (int k = 0; k < n; k++) begin
      step();
      if (sim_state == 2'b11 && prev_st != 2'b11 && current_floor == flr) stops++;
      prev_st = sim_state;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // tick, btn, dest, state, floor, door -- row r is sampled just after edge r+1 following reset release
    vt[0]  = '{1'b1, 8'h02, 8'h00, 2'd0, 3'd0, 1'b0};
    vt[1]  = '{1'b1, 8'h02, 8'h00, 2'd0, 3'd0, 1'b0};
    vt[2]  = '{1'b1, 8'h00, 8'h02, 2'd0, 3'd0, 1'b0};
    vt[3]  = '{1'b1, 8'h00, 8'h02, 2'd1, 3'd0, 1'b0};
    vt[4]  = '{1'b0, 8'h00, 8'h02, 2'd1, 3'd0, 1'b0};
    vt[5]  = '{1'b0, 8'h00, 8'h02, 2'd1, 3'd0, 1'b0};
    vt[6]  = '{1'b1, 8'h00, 8'h02, 2'd1, 3'd0, 1'b0};
    vt[7]  = '{1'b1, 8'h00, 8'h02, 2'd1, 3'd0, 1'b0};
    vt[8]  = '{1'b1, 8'h00, 8'h02, 2'd1, 3'd0, 1'b0};
    vt[9]  = '{1'b0, 8'h00, 8'h02, 2'd1, 3'd0, 1'b0};
    vt[10] = '{1'b1, 8'h00, 8'h00, 2'd3, 3'd1, 1'b1};
    vt[11] = '{1'b0, 8'h00, 8'h00, 2'd3, 3'd1, 1'b1};
    vt[12] = '{1'b1, 8'h00, 8'h00, 2'd3, 3'd1, 1'b1};
    vt[13] = '{1'b1, 8'h00, 8'h00, 2'd3, 3'd1, 1'b1};
    vt[14] = '{1'b1, 8'h00, 8'h00, 2'd0, 3'd1, 1'b0};
    vt[15] = '{1'b1, 8'h02, 8'h00, 2'd0, 3'd1, 1'b0};
    vt[16] = '{1'b1, 8'h02, 8'h00, 2'd0, 3'd1, 1'b0};
    vt[17] = '{1'b1, 8'h00, 8'h02, 2'd0, 3'd1, 1'b0};
    vt[18] = '{1'b1, 8'h00, 8'h00, 2'd3, 3'd1, 1'b1};
    vt[19] = '{1'b1, 8'h02, 8'h00, 2'd3, 3'd1, 1'b1};
    vt[20] = '{1'b1, 8'h02, 8'h00, 2'd3, 3'd1, 1'b1};
    vt[21] = '{1'b1, 8'h00, 8'h00, 2'd3, 3'd1, 1'b1};
    vt[22] = '{1'b1, 8'h00, 8'h00, 2'd3, 3'd1, 1'b1};
    vt[23] = '{1'b1, 8'h00, 8'h00, 2'd3, 3'd1, 1'b1};
    vt[24] = '{1'b1, 8'h00, 8'h00, 2'd0, 3'd1, 1'b0};
    vt[25] = '{1'b1, 8'h01, 8'h00, 2'd0, 3'd1, 1'b0};
    vt[26] = '{1'b1, 8'h01, 8'h00, 2'd0, 3'd1, 1'b0};
    vt[27] = '{1'b1, 8'h00, 8'h01, 2'd0, 3'd1, 1'b0};
    vt[28] = '{1'b1, 8'h00, 8'h01, 2'd2, 3'd1, 1'b0};
    vt[29] = '{1'b1, 8'h00, 8'h01, 2'd2, 3'd1, 1'b0};
    vt[30] = '{1'b1, 8'h00, 8'h01, 2'd2, 3'd1, 1'b0};
    vt[31] = '{1'b1, 8'h00, 8'h01, 2'd2, 3'd1, 1'b0};
    vt[32] = '{1'b1, 8'h00, 8'h00, 2'd3, 3'd0, 1'b1};
    vt[33] = '{1'b1, 8'h00, 8'h00, 2'd3, 3'd0, 1'b1};
    vt[34] = '{1'b1, 8'h00, 8'h00, 2'd3, 3'd0, 1'b1};
    vt[35] = '{1'b1, 8'h00, 8'h00, 2'd0, 3'd0, 1'b0};

    // Reset state while rst is held.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {destination, sim_state, current_floor, door_open}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 36; i++) begin
      tick    = vt[i].tick;
      req_btn = vt[i].btn;
      step();
      check($sformatf("vec%0d", i),
            {destination, sim_state, current_floor, door_open},
            {vt[i].dest, vt[i].st, vt[i].flr, vt[i].door});
    end

    // Single trip 0 -> 5 with exact timing.
    do_reset();
    req_btn = 8'h20;
    step();
    check("p5_dest_e1", destination, 8'h00);
    step();
    check("p5_dest_e2", destination, 8'h00);
    req_btn = 8'h00;
    step();
    check("p5_dest_e3", destination, 8'h20);
    check("p5_state_e3", sim_state, 2'b00);
    step();
    check("p5_state_e4", sim_state, 2'b01);
    repeat (19) step();
    check("p5_e23", {sim_state, current_floor}, {2'b01, 3'd4});
    step();
    check("p5_arrive", {destination, sim_state, current_floor, door_open}, {8'h00, 2'b11, 3'd5, 1'b1});
    step();
    check("p5_door_e25", door_open, 1'b1);
    step();
    check("p5_door_e26", door_open, 1'b1);
    step();
    check("p5_idle_e27", {sim_state, door_open}, {2'b00, 1'b0});

    // Asynchronous reset mid-travel at floor 3.
    do_reset();
    req_btn = 8'h20;
    step();
    step();
    req_btn = 8'h00;
    repeat (15) step();
    check("mid_up_f3", {sim_state, current_floor}, {2'b01, 3'd3});
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", {destination, sim_state, current_floor, door_open}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Sweep up to 4 then reverse down to 0.
    do_reset();
    req_btn = 8'h10;
    step();
    step();
    req_btn = 8'h00;
    seq_st.delete();
    seq_fl.delete();
    prev_st = 2'b00;
    begin
      bit pressed = 0;
      int hold = 0;
      bit done = 0;
      for (int k = 0; k < 200 && !done; k++) begin
        step();
        if (!pressed && sim_state == 2'b01 && current_floor == 3'd2) begin
          req_btn = 8'h01;
          pressed = 1;
          hold = 2;
        end else if (hold > 0) begin
          hold--;
          if (hold == 0) req_btn = 8'h00;
        end
        if (sim_state != prev_st) begin
          seq_st.push_back(sim_state);
          seq_fl.push_back(current_floor);
          prev_st = sim_state;
          if (sim_state == 2'b00) done = 1;
        end
      end
      check("sweep_done", done, 1'b1);
    end
    begin
      logic [1:0] exp_st[5];
      logic [2:0] exp_fl[5];
      exp_st = '{2'b01, 2'b11, 2'b10, 2'b11, 2'b00};
      exp_fl = '{3'd0, 3'd4, 3'd4, 3'd0, 3'd0};
      check("sweep_len", seq_st.size(), 5);
      for (int i = 0; i < 5; i++) begin
        if (i < seq_st.size())
          check($sformatf("sweep_step%0d", i), {seq_st[i], seq_fl[i]}, {exp_st[i], exp_fl[i]});
      end
    end

    // Press for floor 4 landing exactly on the arrival edge at floor 4.
    do_reset();
    req_btn = 8'h20;
    stops   = 0;
    prev_st = 2'b00;
    begin
      bit seen4 = 0;
      for (int k = 1; k <= 40; k++) begin
        step();
        if (k == 2)  req_btn = 8'h00;
        if (k == 17) req_btn = 8'h10;
        if (k == 19) req_btn = 8'h00;
        if (destination[4]) seen4 = 1;
        if (k == 20) check("arrive4_door", {sim_state, current_floor}, {2'b11, 3'd4});
        if (sim_state == 2'b11 && prev_st != 2'b11) stops++;
        prev_st = sim_state;
      end
      check("arrive4_bit_never_set", seen4, 1'b0);
      check("arrive4_stops", stops, 2);
      check("arrive4_final", {destination, sim_state, current_floor}, {8'h00, 2'b00, 3'd5});
    end

    // Held button registers once; a fresh press registers again.
    do_reset();
    req_btn = 8'h40;
    stops   = 0;
    prev_st = 2'b00;
    run_count(50, 3'd6);
    req_btn = 8'h00;
    run_count(20, 3'd6);
    check("hold6_one_stop", stops, 1);
    req_btn = 8'h40;
    run_count(2, 3'd6);
    req_btn = 8'h00;
    run_count(20, 3'd6);
    check("hold6_two_stops", stops, 2);
    check("hold6_final", {destination, sim_state, current_floor}, {8'h00, 2'b00, 3'd6});

`ifdef ELEV_DOOR_HOLD_EN
    do_reset();
    req_btn = 8'h02;
    step();
    step();
    req_btn = 8'h00;
    repeat (6) step();
    check("hold_door_entry", {sim_state, current_floor}, {2'b11, 3'd1});
    door_hold = 1'b1;
    begin
      bit dropped = 0;
      for (int k = 0; k < 10; k++) begin
        step();
        if (!door_open) dropped = 1;
      end
      check("hold_door_stays_open", dropped, 1'b0);
    end
    door_hold = 1'b0;
    step();
    step();
    check("hold_door_release_e2", door_open, 1'b1);
    step();
    check("hold_door_release_e3", {sim_state, door_open}, {2'b00, 1'b0});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/elevator_sequencer.md
ELEVATOR_SEQUENCER -- requirements
Module: elevator_sequencer

Interface
REQ-001 Parameter NUM_FLOORS, 8, number of floors; equals width of destination and req_btn.
REQ-002 Parameter MOVE_TICKS, 16, tick pulses spent travelling one floor.
REQ-003 Parameter DOOR_TICKS, 32, tick pulses the door stays open per stop.
REQ-004 clk  input  1  system clock (pixel-domain clock after divider); single clock domain.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 tick  input  1  one-clk-wide timing enable; all timers advance only on clk edges with tick=1.
REQ-007 req_btn  input  NUM_FLOORS  raw floor call buttons, asynchronous level, 1 = pressed.
REQ-008 destination  output  NUM_FLOORS  pending request mask, bit i = floor i requested; drives the VGA controller destination input.
REQ-009 sim_state  output  2  FSM state code for display: 00 IDLE, 01 UP, 10 DOWN, 11 DOOR.
REQ-010 current_floor  output  $clog2(NUM_FLOORS)  floor the car is at or last passed.
REQ-011 door_open  output  1  high exactly while sim_state = DOOR.

Function
REQ-012 Each req_btn bit SHALL pass a 2-flop synchronizer then a rising-edge detector; a press sets its destination bit on the 3rd clk edge after the input rises.
REQ-013 Held buttons SHALL set the bit once; re-press requires release for at least 2 clk.
REQ-014 IDLE: bit at current_floor set -> DOOR; else any bit above -> UP; else any bit below -> DOWN; else stay; transition on next clk, independent of tick.
REQ-015 UP/DOWN: move counter counts ticks 0..MOVE_TICKS-1; on tick at MOVE_TICKS-1, current_floor +/-1 and counter returns to 0.
REQ-016 On arrival, if new floor's bit is set -> DOOR and that bit clears same edge; else continue same direction.
REQ-017 UP SHALL only be entered/continued with a pending bit above current_floor (DOWN: below), so current_floor never leaves 0..NUM_FLOORS-1.
REQ-018 DOOR: door counter counts ticks to DOOR_TICKS-1, then exits: pending in last travel direction -> that direction; else opposite direction pending -> opposite; else IDLE.
REQ-019 Last travel direction register SHALL reset to UP and update on every UP/DOWN entry.
REQ-020 Press for current_floor while in DOOR SHALL not set the bit and SHALL restart the door counter to 0.
REQ-021 Simultaneous set and clear of the same bit (press arriving on arrival edge): clear wins, stop is serviced.
REQ-022 Presses for other floors are accepted in every state, including same cycle as transitions.

Reset
REQ-023 rst asynchronously clears: synchronizers, edge flops, destination=0, sim_state=IDLE, current_floor=0, door_open=0, both counters=0, direction=UP.
REQ-024 Reset asserted mid-travel or mid-door SHALL abandon the operation; presses during reset are discarded.
REQ-025 Release of rst SHALL be glitch-free relative to clk; first request accepted 3 clk after release.

Configuration
REQ-026 Macro ELEV_DOOR_HOLD_EN: when defined, adds input door_hold (1 bit); while door_hold=1 in DOOR, door counter holds at 0 and DOOR is not exited.
REQ-027 Without ELEV_DOOR_HOLD_EN the port is absent and DOOR always exits after DOOR_TICKS ticks.

Structure
REQ-028 Shared package elevator_pkg SHALL hold the sim_state enum (IDLE, UP, DOWN, DOOR with codes of REQ-009), default NUM_FLOORS, and floor index type.
REQ-029 Sub-module btn_sync_edge (2-flop sync + rising-edge pulse, parameterized width) SHALL be instantiated once for req_btn.
REQ-030 vgaController consumes destination and sim_state unmodified; no encoding in between.

Verification (MOVE_TICKS=4, DOOR_TICKS=3, tick every clk)
REQ-031 Reset: assert rst mid-UP at floor 3 -> all outputs 0/IDLE immediately, before next clk edge.
REQ-032 Press floor 5 from idle at floor 0 -> destination=0x20 after 3 clk; UP; floor 5 reached after 20 ticks; DOOR, destination=0x00, door_open for 3 ticks, then IDLE.
REQ-033 At floor 2 moving UP with pending 0x10 and 0x01 -> stops at 4, then reverses DOWN to 0; sim_state sequence 01,11,10,11,00.
REQ-034 Press floor 4 exactly on arrival edge at floor 4 -> bit never observed set, DOOR entered.
REQ-035 Hold req_btn[6] high 50 clk, release, press again after service -> exactly two stops at floor 6.
REQ-036 With ELEV_DOOR_HOLD_EN, door_hold=1 for 10 ticks in DOOR -> door_open stays 1, exits 3 ticks after door_hold falls.
